// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised single-clock FIFO for the UART datapath (RX/TX shifters on
//   one side, bus register interface on the other).
//
//   Parameters
//     BW        element width in bits
//     LGFLEN    log2 of depth, D = 2**LGFLEN
//     FWFT      0: o_data updates on the edge that accepts a read
//               1: head element presented on o_data whenever not empty
//     AF_THRESH o_almost_full  when fill >= AF_THRESH (1..D)
//     AE_THRESH o_almost_empty when fill <= AE_THRESH (0..D-1)
//
//   Ports
//     i_clk, i_rst_n       clock, async active-low reset
//     i_flush              synchronous clear of contents and error flags
//     i_wr, i_data         write request and data
//     i_rd, o_data         read request and data
//     o_full, o_empty      fill == D / fill == 0
//     o_almost_full/empty  threshold flags
//     o_fill               element count 0..D
//     o_overflow/underflow sticky error flags, cleared by flush or reset
module fifo_sync_param #(
  parameter int unsigned BW        = 8,
  parameter int unsigned LGFLEN    = 4,
  parameter bit          FWFT      = 1'b0,
  parameter int unsigned AF_THRESH = (1 << LGFLEN) - 2,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int unsigned     D        = 1 << LGFLEN;
  localparam logic [LGFLEN:0] FILL_MAX = (LGFLEN+1)'(D);
  localparam logic [LGFLEN:0] AF_L     = (LGFLEN+1)'(AF_THRESH);
  localparam logic [LGFLEN:0] AE_L     = (LGFLEN+1)'(AE_THRESH);

  logic [BW-1:0]     mem_q [D];
  logic [LGFLEN-1:0] wr_ptr_q, wr_ptr_d;
  logic [LGFLEN-1:0] rd_ptr_q, rd_ptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_ok, wr_ok;

  // A write into a full FIFO is accepted only when a read frees a slot in
  // the same cycle.
  assign rd_ok = i_rd & ~empty_q;
  assign wr_ok = i_wr & (~full_q | rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + LGFLEN'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + LGFLEN'(1);
      case ({wr_ok, rd_ok})
        2'b10:   fill_d = fill_q + (LGFLEN+1)'(1);
        2'b01:   fill_d = fill_q - (LGFLEN+1)'(1);
        default: fill_d = fill_q;
      endcase
      if (i_wr && !wr_ok) ovf_d = 1'b1;
      if (i_rd && !rd_ok) unf_d = 1'b1;
    end
    // Flags come from the next fill so they line up with o_fill.
    full_d  = (fill_d == FILL_MAX);
    empty_d = (fill_d == '0);
    af_d    = (fill_d >= AF_L);
    ae_d    = (fill_d <= AE_L);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge i_clk) begin
    if (!i_flush && wr_ok) mem_q[wr_ptr_q] <= i_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // Contents are undefined when empty; drive zero so reset shows 0.
      assign o_data = empty_q ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [BW-1:0] rdata_q;
      // Full with simultaneous read/write: wr_ptr == rd_ptr, and the read
      // here sees the old entry because the write lands at the same edge.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 rdata_q <= '0;
        else if (!i_flush && rd_ok)   rdata_q <= mem_q[rd_ptr_q];
      end
      assign o_data = rdata_q;
    end
  endgenerate

  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
  assign o_fill         = fill_q;
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous FIFO: the next generation of the UART buffer FIFO, generalised in data width and depth.
- Adds almost-full/almost-empty thresholds, a selectable read mode (standard or first-word-fall-through), synchronous flush, and sticky overflow/underflow error flags.
- Sits between the UART RX/TX shifters and the bus-side register interface; one clock domain.

Parameters:
BW, 8, bits per element
LGFLEN, 4, log2 of depth; depth D = 2^LGFLEN
FWFT, 0, 0 = standard read (data one cycle after read); 1 = head element always presented on o_data
AF_THRESH, D-2, o_almost_full asserts when fill >= AF_THRESH (legal range 1..D)
AE_THRESH, 1, o_almost_empty asserts when fill <= AE_THRESH (legal range 0..D-1)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_flush  input  1  synchronous clear of contents and errors
i_wr  input  1  write request
i_data  input  BW  write data
i_rd  input  1  read request
o_data  output  BW  read data
o_full  output  1  fill == D
o_empty  output  1  fill == 0
o_almost_full  output  1  fill >= AF_THRESH
o_almost_empty  output  1  fill <= AE_THRESH
o_fill  output  LGFLEN+1  number of stored elements, 0..D
o_overflow  output  1  sticky: write rejected because full
o_underflow  output  1  sticky: read rejected because empty

Behaviour:
- Storage: D x BW register array. Write and read pointers are LGFLEN bits and wrap modulo D. Fill is a separate LGFLEN+1-bit counter.
- Reset (async assert, sync release), all outputs:
  - o_fill = 0, o_empty = 1, o_full = 0
  - o_almost_empty = 1, o_almost_full = 0 (for legal thresholds)
  - o_overflow = 0, o_underflow = 0, o_data = 0
  - Pointers = 0. Memory contents are not reset.
  - Reset mid-operation discards all contents immediately.
- Accept rules, evaluated per cycle on current state:
  - rd_ok = i_rd and not o_empty.
  - wr_ok = i_wr and (not o_full or rd_ok). Simultaneous read and write while full is accepted; fill stays D.
  - When empty, simultaneous read and write: write accepted, read rejected, underflow set.
- Fill update: +1 on wr_ok only; -1 on rd_ok only; unchanged when both or neither.
- Status flags are all registered and derived from the next fill, so they are consistent with o_fill in the same cycle.
- Errors:
  - i_wr while full and no accepted read: element dropped, no memory or pointer change, o_overflow = 1 from the next cycle.
  - i_rd while empty: no state change, o_underflow = 1 from the next cycle.
  - Both error flags hold until i_flush or reset.
- Flush: on a rising edge with i_flush = 1:
  - Pointers, fill and error flags clear; o_empty = 1 next cycle.
  - Same-cycle i_wr and i_rd are ignored (flush has priority).
  - o_data is not cleared.
- Read data, FWFT = 0: on rd_ok, o_data takes mem[rd_ptr] at that edge, so data is valid from the cycle after the read. o_data holds its value otherwise.
- Read data, FWFT = 1: o_data = mem[rd_ptr], combinational from registered state, and is valid whenever o_empty = 0.
  - A write to an empty FIFO appears on o_data, with o_empty low, one cycle after the write edge.
  - rd_ok advances to the next element at the edge.
  - When empty, o_data is don't-care.
- Wrap-around: pointers roll from D-1 to 0 with no gap or duplication. Order is strictly FIFO across wraps.

Test Plan:
1. Reset, then LGFLEN = 4, FWFT = 0: write 0..15 on consecutive cycles -> o_full = 1 and o_fill = 16 after the 16th edge; o_almost_full first high when o_fill = 14. Write 0xAA -> o_overflow = 1, o_fill stays 16. Read 16 -> o_data = 0..15, each one cycle after its read; 0xAA never appears.
2. Full FIFO, i_wr and i_rd high together for 4 cycles with data 0x50..0x53 -> o_fill stays 16, o_overflow stays 0. Draining returns the remaining originals, then 0x50..0x53.
3. Wrap-around: write 10, read 10, then write 0x20..0x2F and read 16 -> order preserved; o_empty = 1 and o_almost_empty = 1 at the end.
4. Empty FIFO, assert i_rd -> o_underflow = 1, o_fill = 0. Same cycle i_wr = 1 with 0x77 -> o_fill = 1.
5. FWFT = 1: write 0x3C into empty -> next cycle o_empty = 0 and o_data = 0x3C with no read issued. Read -> o_empty = 1 next cycle.
6. Fill with 9 elements with o_overflow set, then either:
   - pulse i_flush with i_wr high -> next cycle o_fill = 0, o_empty = 1, o_overflow = 0, write ignored; or
   - deassert i_rst_n mid-burst -> all outputs at reset values immediately, without waiting for a clock edge.
